cls_result_ahb_master: RTL and testbench
========================================

Name: cls_result_ahb_master

Overview:
- AHB-Lite single-master write engine upstream of the seven-segment display slave.
- Accepts classifier results (5-bit class index, valid/ready) into a small FIFO.
- For each result it issues two single NONSEQ 32-bit writes: class value to BASE_ADDR+0x0 (data_reg), then 0x1 to BASE_ADDR+0x4 (done flag).
- Enforces a minimum spacing between display updates and reports bus errors.

Parameters:
- BASE_ADDR, 32'hC000_0000, display slave base address.
- FIFO_DEPTH, 2, result buffer entries (power of 2, ≥2).
- CLASS_MAX, 23, largest valid class; values above it are written as 31.
- MIN_GAP, 1024, minimum cycles from the end of one flag data phase to the next data_reg address phase.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- result_valid_i  in  1  result present
- result_class_i  in  5  class index
- result_ready_o  out  1  FIFO not full
- ahb_m_haddr_o  out  32  address
- ahb_m_hwrite_o  out  1  write
- ahb_m_hsize_o  out  3  fixed 3'b010
- ahb_m_hburst_o  out  3  fixed 3'b000
- ahb_m_hprot_o  out  4  fixed 4'b0000
- ahb_m_htrans_o  out  2  IDLE=2'b00 / NONSEQ=2'b10 only
- ahb_m_hmastlock_o  out  1  fixed 0
- ahb_m_hwdata_o  out  32  write data
- ahb_m_hready_i  in  1  slave ready
- ahb_m_hresp_i  in  1  slave error
- busy_o  out  1  sequence in progress
- err_o  out  1  sticky bus error
- wr_count_o  out  16  completed result writes

Behaviour:
- Reset values: htrans=IDLE, haddr=0, hwrite=0, hwdata=0, busy_o=0, err_o=0, wr_count_o=0, FIFO empty, gap counter=0 (first write not delayed). result_ready_o=1 from the first cycle after reset.
- All AHB outputs are registered. A phase advances only on a clk edge with hready_i=1; address/data are held stable while hready_i=0.
- FIFO behaviour:
  - Push when valid&&ready. Pop at completion of the flag data phase.
  - Simultaneous push and pop when full is allowed (ready reflects pre-pop state, so no push in that cycle).
  - Pointers wrap modulo FIFO_DEPTH.
- Clamp: written value is {27'b0, cls}, where cls = (class > CLASS_MAX) ? 5'd31 : class. Clamping is applied at pop/issue time, not at push.
- FSM:
  - IDLE: htrans=IDLE. If FIFO non-empty and gap counter==0 → A_DATA.
  - A_DATA: haddr=BASE, hwrite=1, htrans=NONSEQ. On hready → D_DATA.
  - D_DATA: pipelined. Drives hwdata=cls while presenting the second address (haddr=BASE+4, NONSEQ, hwrite=1). On hready → D_FLAG.
  - D_FLAG: htrans=IDLE, hwrite=0, hwdata=32'h1. On hready → pop, wr_count_o+=1 (wraps at 16'hFFFF→0), gap counter=MIN_GAP → IDLE.
  - Gap counter decrements to 0 in IDLE.
  - Minimum sequence length with zero wait states: 3 cycles of busy_o.
- busy_o = 1 in every state except IDLE.
- Error handling:
  - hresp_i=1 while in D_DATA or D_FLAG: on the first error cycle (hready=0), force htrans=IDLE on the next edge; hold until hready=1.
  - Then pop and discard the entry, set err_o (cleared only by reset), do not increment wr_count_o, load gap counter → IDLE.
- Reset asserted mid-sequence: all state returns to reset values next edge; buffered results are lost.

Test Plan:
- Reset, zero-wait slave, MIN_GAP=4, push class 5 → NONSEQ @C000_0000 with hwdata=5 next phase, NONSEQ @C000_0004 with hwdata=1; wr_count_o=1, busy_o high exactly 3 cycles.
- Push 30 → hwdata=31 written to C000_0000. Push 23 → 23 written unclamped.
- Slave inserts 2 wait states per data phase → haddr/hwdata held stable during hready=0; sequence completes in 7 cycles; single flag write.
- Push 3 results back-to-back with FIFO_DEPTH=2 → result_ready_o low after 2 accepted; third accepted after first pop. Next data_reg address phase starts no earlier than MIN_GAP cycles after each flag phase. Values written in order.
- Slave returns a two-cycle ERROR on the data_reg write → htrans=IDLE after the first error cycle, no flag write, err_o=1 sticky, wr_count_o unchanged; next result proceeds normally.
- Assert reset during D_DATA with 2 entries queued → outputs return to reset values next cycle, FIFO empty, no further writes.

Source files
------------

// File: rtl/cls_result_ahb_master_if.sv
// Bundles the classifier-result handshake and the AHB-Lite master bus of
// cls_result_ahb_master.
//   master modport : the write engine (drives result_ready_o and the AHB request)
//   slave  modport : the environment (result producer plus AHB slave)
// Signal names keep the engine-side _i/_o suffixes so both ends read the same.
interface cls_result_ahb_master_if;
  logic        result_valid_i;
  logic [4:0]  result_class_i;
  logic        result_ready_o;
  logic [31:0] ahb_m_haddr_o;
  logic        ahb_m_hwrite_o;
  logic [2:0]  ahb_m_hsize_o;
  logic [2:0]  ahb_m_hburst_o;
  logic [3:0]  ahb_m_hprot_o;
  logic [1:0]  ahb_m_htrans_o;
  logic        ahb_m_hmastlock_o;
  logic [31:0] ahb_m_hwdata_o;
  logic        ahb_m_hready_i;
  logic        ahb_m_hresp_i;

  modport master (
    input  result_valid_i, result_class_i, ahb_m_hready_i, ahb_m_hresp_i,
    output result_ready_o, ahb_m_haddr_o, ahb_m_hwrite_o, ahb_m_hsize_o,
           ahb_m_hburst_o, ahb_m_hprot_o, ahb_m_htrans_o, ahb_m_hmastlock_o,
           ahb_m_hwdata_o
  );

  modport slave (
    output result_valid_i, result_class_i, ahb_m_hready_i, ahb_m_hresp_i,
    input  result_ready_o, ahb_m_haddr_o, ahb_m_hwrite_o, ahb_m_hsize_o,
           ahb_m_hburst_o, ahb_m_hprot_o, ahb_m_htrans_o, ahb_m_hmastlock_o,
           ahb_m_hwdata_o
  );
endinterface

// File: rtl/cls_result_ahb_master.sv
// AHB-Lite single-master write engine feeding the seven-segment display slave.
// Each buffered classifier result becomes two single NONSEQ word writes:
// the (clamped) class to BASE_ADDR+0x0, then 0x1 to BASE_ADDR+0x4.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   bus          : result valid/ready handshake and AHB master signals
//   busy_o       : a write sequence is in progress
//   err_o        : sticky, set when a sequence is abandoned on an ERROR response
//   wr_count_o   : number of results fully written (wraps at 16 bits)
module cls_result_ahb_master #(
  parameter logic [31:0] BASE_ADDR  = 32'hC000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          CLASS_MAX  = 23,
  parameter int          MIN_GAP    = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  cls_result_ahb_master_if.master bus,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [15:0]            wr_count_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam logic [PTR_W:0]   DEPTH_C     = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_C       = GAP_W'(MIN_GAP);
  localparam logic [4:0]       CLASS_MAX_C = 5'(CLASS_MAX);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // D_ERR holds the bus idle until the second cycle of an ERROR response.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_A_DATA = 3'd1;
  localparam logic [2:0] S_D_DATA = 3'd2;
  localparam logic [2:0] S_D_FLAG = 3'd3;
  localparam logic [2:0] S_D_ERR  = 3'd4;

  logic [4:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [2:0]       state_q, state_d;
  logic [4:0]       cls_q, cls_d;
  logic [31:0]      haddr_q, haddr_d, hwdata_q, hwdata_d;
  logic             hwrite_q, hwrite_d;
  logic [1:0]       htrans_q, htrans_d;
  logic             err_q, err_d;
  logic [15:0]      wr_count_q, wr_count_d;

  logic             result_ready;
  logic             push, pop, err_done;
  logic [4:0]       head;

  // Ready reflects the pre-pop occupancy, so a full FIFO never pushes in
  // the same cycle it pops.
  assign result_ready = (count_q != DEPTH_C);
  assign push         = bus.result_valid_i && result_ready;
  assign head         = fifo_mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= bus.result_class_i;
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    gap_d      = gap_q;
    cls_d      = cls_q;
    haddr_d    = haddr_q;
    hwdata_d   = hwdata_q;
    hwrite_d   = hwrite_q;
    htrans_d   = htrans_q;
    err_d      = err_q;
    wr_count_d = wr_count_q;
    pop        = 1'b0;
    err_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (count_q != '0) begin
          state_d  = S_A_DATA;
          haddr_d  = BASE_ADDR;
          hwrite_d = 1'b1;
          htrans_d = HTRANS_NONSEQ;
          // Clamp at issue time; the FIFO keeps the raw class.
          cls_d    = (head > CLASS_MAX_C) ? 5'd31 : head;
        end
      end
      S_A_DATA: begin
        if (bus.ahb_m_hready_i) begin
          state_d  = S_D_DATA;
          haddr_d  = BASE_ADDR + 32'h4;
          hwdata_d = {27'd0, cls_q};
        end
      end
      S_D_DATA: begin
        if (bus.ahb_m_hresp_i) begin
          if (bus.ahb_m_hready_i) begin
            err_done = 1'b1;
          end else begin
            // First ERROR cycle: cancel the pending flag address phase.
            state_d  = S_D_ERR;
            htrans_d = HTRANS_IDLE;
            hwrite_d = 1'b0;
          end
        end else if (bus.ahb_m_hready_i) begin
          state_d  = S_D_FLAG;
          htrans_d = HTRANS_IDLE;
          hwrite_d = 1'b0;
          hwdata_d = 32'h1;
        end
      end
      S_D_FLAG: begin
        if (bus.ahb_m_hresp_i) begin
          if (bus.ahb_m_hready_i) err_done = 1'b1;
          else                    state_d  = S_D_ERR;
        end else if (bus.ahb_m_hready_i) begin
          pop        = 1'b1;
          wr_count_d = wr_count_q + 16'd1;
          gap_d      = GAP_C;
          state_d    = S_IDLE;
        end
      end
      S_D_ERR: begin
        if (bus.ahb_m_hready_i) err_done = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // An errored result is discarded but still spaces the next update.
    if (err_done) begin
      pop      = 1'b1;
      err_d    = 1'b1;
      gap_d    = GAP_C;
      state_d  = S_IDLE;
      htrans_d = HTRANS_IDLE;
      hwrite_d = 1'b0;
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      gap_q      <= '0;
      cls_q      <= '0;
      haddr_q    <= '0;
      hwdata_q   <= '0;
      hwrite_q   <= 1'b0;
      htrans_q   <= HTRANS_IDLE;
      err_q      <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      gap_q      <= gap_d;
      cls_q      <= cls_d;
      haddr_q    <= haddr_d;
      hwdata_q   <= hwdata_d;
      hwrite_q   <= hwrite_d;
      htrans_q   <= htrans_d;
      err_q      <= err_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign bus.result_ready_o    = result_ready;
  assign bus.ahb_m_haddr_o     = haddr_q;
  assign bus.ahb_m_hwrite_o    = hwrite_q;
  assign bus.ahb_m_hsize_o     = 3'b010;
  assign bus.ahb_m_hburst_o    = 3'b000;
  assign bus.ahb_m_hprot_o     = 4'b0000;
  assign bus.ahb_m_htrans_o    = htrans_q;
  assign bus.ahb_m_hmastlock_o = 1'b0;
  assign bus.ahb_m_hwdata_o    = hwdata_q;
  assign busy_o                = (state_q != S_IDLE);
  assign err_o                 = err_q;
  assign wr_count_o            = wr_count_q;
endmodule

// File: tb/tb_cls_result_ahb_master.sv
// Bench for cls_result_ahb_master: directed result pushes, a configurable AHB
// slave (wait states, two-cycle ERROR), and a transaction-level model that
// predicts the writes, counters and handshake every cycle.
module tb_cls_result_ahb_master;
  localparam logic [31:0] BASE  = 32'hC000_0000;
  localparam int          DEPTH = 2;
  localparam int          CMAX  = 23;
  localparam int          GAP   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy, err;
  logic [15:0] wr_count;

  cls_result_ahb_master_if bus_if();

  cls_result_ahb_master #(
    .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .CLASS_MAX(CMAX), .MIN_GAP(GAP)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_if),
    .busy_o(busy), .err_o(err), .wr_count_o(wr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] clampv(input logic [4:0] v);
    return (int'(v) > CMAX) ? 32'd31 : {27'd0, v};
  endfunction

  // ---------------- model / slave state ----------------
  bit          mon_en = 1'b0;
  int          cyc = 0;
  int          wait_cfg = 0;
  bit          err_arm = 1'b0;
  logic [4:0]  exp_q[$];
  int          occ = 0;
  int          m_count = 0;
  bit          m_err = 1'b0;
  bit          seq_open = 1'b0;
  int          seq_busy = 0;
  int          seq_addr_n = 0;
  int          seq_len_last = 0;
  bit          dp_active = 1'b0;
  logic [31:0] dp_addr = '0;
  bit          dp_err = 1'b0;
  int          dp_k = 0;
  int          last_end = 0;
  bit          last_end_v = 1'b0;
  bit          hold_v = 1'b0;
  logic [31:0] h_addr, h_wdata;
  logic [1:0]  h_trans;
  logic        h_write;
  bit          expect_idle = 1'b0;
  int          stall_n = 0;
  int          writes_n = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        nx_ready = 1'b1;
  logic        nx_resp = 1'b0;

  task automatic monitor_cycle();
    logic        rdy, resp, opening, pushed, popped;
    logic [1:0]  trans;
    logic [31:0] addr, wdata;
    logic        write;
    rdy   = bus_if.ahb_m_hready_i;
    resp  = bus_if.ahb_m_hresp_i;
    trans = bus_if.ahb_m_htrans_o;
    addr  = bus_if.ahb_m_haddr_o;
    wdata = bus_if.ahb_m_hwdata_o;
    write = bus_if.ahb_m_hwrite_o;
    pushed = 1'b0;
    popped = 1'b0;

    chk("hsize", 32'(bus_if.ahb_m_hsize_o), 32'd2);
    chk("hburst", 32'(bus_if.ahb_m_hburst_o), 32'd0);
    chk("hprot", 32'(bus_if.ahb_m_hprot_o), 32'd0);
    chk("hmastlock", 32'(bus_if.ahb_m_hmastlock_o), 32'd0);
    chk("htrans_legal", 32'(trans == 2'b00 || trans == 2'b10), 32'd1);
    chk("result_ready", 32'(bus_if.result_ready_o), 32'(occ < DEPTH));
    chk("wr_count", 32'(wr_count), 32'(m_count[15:0]));
    chk("err", 32'(err), 32'(m_err));
    opening = !seq_open && (trans == 2'b10);
    chk("busy", 32'(busy), 32'(seq_open || opening));
    if (hold_v) begin
      chk("hold_haddr", addr, h_addr);
      chk("hold_htrans", 32'(trans), 32'(h_trans));
      chk("hold_hwrite", 32'(write), 32'(h_write));
      chk("hold_hwdata", wdata, h_wdata);
    end
    if (expect_idle) chk("err_htrans_idle", 32'(trans), 32'd0);
    hold_v = 1'b0;
    expect_idle = 1'b0;

    if (reset) begin
      exp_q.delete();
      occ = 0; m_count = 0; m_err = 1'b0;
      seq_open = 1'b0; dp_active = 1'b0; last_end_v = 1'b0;
      nx_ready = 1'b1; nx_resp = 1'b0;
      return;
    end

    if (bus_if.result_valid_i && !bus_if.result_ready_o) stall_n++;

    if (opening) begin
      chk("issue_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (last_end_v) chk("min_gap", 32'(cyc - last_end - 1 >= GAP), 32'd1);
      seq_open = 1'b1;
      seq_busy = 0;
      seq_addr_n = 0;
    end
    if (seq_open) seq_busy++;

    // data phase of an earlier accepted address
    if (dp_active && rdy) begin
      if (dp_err) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        popped = 1'b1;
        m_err = 1'b1;
        seq_open = 1'b0;
        last_end = cyc; last_end_v = 1'b1;
      end else begin
        log_addr.push_back(dp_addr);
        log_data.push_back(wdata);
        writes_n++;
        chk("write_has_result", 32'(exp_q.size() > 0), 32'd1);
        if (dp_addr == BASE) begin
          if (exp_q.size() > 0) chk("data_reg_value", wdata, clampv(exp_q[0]));
        end else begin
          chk("flag_value", wdata, 32'd1);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          popped = 1'b1;
          m_count++;
          seq_open = 1'b0;
          last_end = cyc; last_end_v = 1'b1;
          seq_len_last = seq_busy;
          chk("seq_busy_cycles", 32'(seq_busy), 32'(3 + 2 * wait_cfg));
        end
      end
      dp_active = 1'b0;
    end else if (dp_active && !rdy) begin
      if (resp) begin
        expect_idle = 1'b1;
      end else begin
        hold_v = 1'b1;
        h_addr = addr; h_trans = trans; h_write = write; h_wdata = wdata;
      end
    end

    // address phase accepted this cycle
    if (trans == 2'b10 && rdy) begin
      chk("haddr", addr, (seq_addr_n == 0) ? BASE : BASE + 32'h4);
      chk("hwrite", 32'(write), 32'd1);
      chk("addr_per_seq", 32'(seq_addr_n < 2), 32'd1);
      seq_addr_n++;
      dp_active = 1'b1;
      dp_addr = addr;
      dp_k = 0;
      dp_err = err_arm && (addr == BASE);
      if (dp_err) err_arm = 1'b0;
    end

    if (bus_if.result_valid_i && bus_if.result_ready_o) begin
      exp_q.push_back(bus_if.result_class_i);
      pushed = 1'b1;
    end
    occ = occ + int'(pushed) - int'(popped);

    // slave response for the next cycle
    if (dp_active) begin
      if (dp_err) begin
        nx_ready = (dp_k >= 1);
        nx_resp  = 1'b1;
      end else begin
        nx_ready = (dp_k >= wait_cfg);
        nx_resp  = 1'b0;
      end
      dp_k++;
    end else begin
      nx_ready = 1'b1;
      nx_resp  = 1'b0;
    end
  endtask

  initial begin
    bus_if.ahb_m_hready_i = 1'b1;
    bus_if.ahb_m_hresp_i  = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (mon_en) monitor_cycle();
      @(posedge clk);
      #1;
      bus_if.ahb_m_hready_i = nx_ready;
      bus_if.ahb_m_hresp_i  = nx_resp;
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge after acceptance with valid
  // still high so pushes can run back to back.
  task automatic push(input logic [4:0] v);
    bit accepted;
    accepted = 1'b0;
    bus_if.result_valid_i = 1'b1;
    bus_if.result_class_i = v;
    for (int i = 0; i < 400 && !accepted; i++) begin
      if (bus_if.result_ready_o) accepted = 1'b1;
      @(negedge clk);
    end
    chk("push_accepted", 32'(accepted), 32'd1);
  endtask

  task automatic drop();
    bus_if.result_valid_i = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < 400 && writes_n < n; i++) @(negedge clk);
    chk("writes_reached", 32'(writes_n >= n), 32'd1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    bit found;
    reset = 1'b1;
    bus_if.result_valid_i = 1'b0;
    bus_if.result_class_i = 5'd0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_htrans", 32'(bus_if.ahb_m_htrans_o), 32'd0);
    chk("rst_haddr", bus_if.ahb_m_haddr_o, 32'd0);
    chk("rst_hwrite", 32'(bus_if.ahb_m_hwrite_o), 32'd0);
    chk("rst_hwdata", bus_if.ahb_m_hwdata_o, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_ready", 32'(bus_if.result_ready_o), 32'd1);
    reset = 1'b0;
    mon_en = 1'b1;
    wait_cycles(2);

    // single result, zero wait states
    push(5'd5); drop();
    wait_writes(2);
    wait_cycles(2);
    chk("t1_addr0", log_addr[0], 32'hC000_0000);
    chk("t1_data0", log_data[0], 32'd5);
    chk("t1_addr1", log_addr[1], 32'hC000_0004);
    chk("t1_data1", log_data[1], 32'd1);
    chk("t1_busy_len", 32'(seq_len_last), 32'd3);
    chk("t1_wr_count", 32'(wr_count), 32'd1);

    // clamping
    push(5'd30); drop();
    wait_writes(4);
    chk("t2_addr", log_addr[2], 32'hC000_0000);
    chk("t2_clamped", log_data[2], 32'd31);
    push(5'd23); drop();
    wait_writes(6);
    chk("t2_unclamped", log_data[4], 32'd23);

    // two wait states per data phase
    wait_cycles(GAP + 4);
    wait_cfg = 2;
    push(5'd9); drop();
    wait_writes(8);
    wait_cycles(2);
    chk("t3_busy_len", 32'(seq_len_last), 32'd7);
    chk("t3_data", log_data[6], 32'd9);
    chk("t3_flag_addr", log_addr[7], 32'hC000_0004);
    chk("t3_wr_count", 32'(wr_count), 32'd4);
    wait_cycles(GAP + 4);
    wait_cfg = 0;

    // three back to back into a two-entry FIFO
    stall_n = 0;
    push(5'd1); push(5'd2); push(5'd3); drop();
    wait_writes(14);
    wait_cycles(2);
    chk("t4_stalled", 32'(stall_n > 0), 32'd1);
    chk("t4_order0", log_data[8], 32'd1);
    chk("t4_order1", log_data[10], 32'd2);
    chk("t4_order2", log_data[12], 32'd3);
    chk("t4_wr_count", 32'(wr_count), 32'd7);
    wait_cycles(GAP + 4);

    // ERROR on the data_reg write, then a normal result
    err_arm = 1'b1;
    push(5'd7); drop();
    for (int i = 0; i < 100 && !m_err; i++) @(negedge clk);
    wait_cycles(2);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_wr_count", 32'(wr_count), 32'd7);
    chk("t5_no_writes", 32'(writes_n), 32'd14);
    push(5'd12); drop();
    wait_writes(16);
    wait_cycles(2);
    chk("t5_next_data", log_data[14], 32'd12);
    chk("t5_next_wr_count", 32'(wr_count), 32'd8);
    chk("t5_err_sticky", 32'(err), 32'd1);
    wait_cycles(GAP + 4);

    // reset during D_DATA with two entries queued
    push(5'd4); push(5'd6); drop();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus_if.ahb_m_htrans_o == 2'b10 && bus_if.ahb_m_haddr_o == BASE + 32'h4) found = 1'b1;
    end
    chk("t6_reached_d_data", 32'(found), 32'd1);
    chk("t6_fifo_full", 32'(bus_if.result_ready_o), 32'd0);
    reset = 1'b1;
    saved = writes_n;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_htrans", 32'(bus_if.ahb_m_htrans_o), 32'd0);
    chk("t6_haddr", bus_if.ahb_m_haddr_o, 32'd0);
    chk("t6_hwdata", bus_if.ahb_m_hwdata_o, 32'd0);
    chk("t6_hwrite", 32'(bus_if.ahb_m_hwrite_o), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_wr_count", 32'(wr_count), 32'd0);
    chk("t6_ready", 32'(bus_if.result_ready_o), 32'd1);
    wait_cycles(40);
    chk("t6_no_more_writes", 32'(writes_n), 32'(saved));
    chk("t6_still_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
